// File: rtl/mbgd_grad_sched_if.sv
// Gradient output stream: one word per column with its column index.
// Ports: grad_valid/grad_addr/grad_data from the scheduler, grad_ready from the consumer.
interface mbgd_grad_sched_if #(
  parameter int DW      = 8,
  parameter int COL_BIT = 3
);
  logic               grad_valid;
  logic               grad_ready;
  logic [COL_BIT-1:0] grad_addr;
  logic [2*DW-1:0]    grad_data;

  modport master (
    output grad_valid,
    output grad_addr,
    output grad_data,
    input  grad_ready
  );

  modport slave (
    input  grad_valid,
    input  grad_addr,
    input  grad_data,
    output grad_ready
  );
endinterface

// File: rtl/mbgd_grad_sched.sv
// MBGD phase-2 gradient scheduler: reads X columns, feeds the datapath, emits one gradient per column.
// Ports: clk, resetn (sync, 1=reset), start/busy/done, col_rd_en/col_addr/x_col_in (column memory),
//   dp_enable/dp_x_col/dp_g (datapath), gs (gradient valid/ready stream, master side).
module mbgd_grad_sched #(
  parameter int DW       = 8,
  parameter int N        = 8,
  parameter int NUM_COLS = 8,
  parameter int COL_BIT  = 3,
  parameter int LAT      = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               col_rd_en,
  output logic [COL_BIT-1:0] col_addr,
  input  logic [DW*N-1:0]    x_col_in,
  output logic               dp_enable,
  output logic [DW*N-1:0]    dp_x_col,
  input  logic [2*DW-1:0]    dp_g,
  mbgd_grad_sched_if.master  gs
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int            CW = COL_BIT + 1;
  localparam logic [CW-1:0] NC = CW'(NUM_COLS);

  state_t             state_q;
  logic [CW-1:0]      issue_q;
  logic [CW-1:0]      acc_q;
  logic [COL_BIT-1:0] ret_q;
  logic               rd_pend_q;
  logic               skid_vld_q;
  logic [DW*N-1:0]    skid_q;
  logic [DW*N-1:0]    dp_x_col_q;
  logic               in_vld_q;
  logic [COL_BIT-1:0] in_idx_q;
  logic [LAT-1:0]     vld_q;
  logic [COL_BIT-1:0] idx_q [LAT];

  logic run;
  logic stall;
  logic xfer;

  assign run       = (state_q == RUN);
  assign stall     = gs.grad_valid & ~gs.grad_ready;
  assign xfer      = gs.grad_valid & gs.grad_ready;
  assign dp_enable = run & ~stall;
  assign col_rd_en = dp_enable & (issue_q < NC);
  assign col_addr  = issue_q[COL_BIT-1:0];
  assign dp_x_col  = dp_x_col_q;
  assign busy      = run;
  assign done      = (state_q == DONE);

  assign gs.grad_valid = vld_q[LAT-1];
  assign gs.grad_addr  = idx_q[LAT-1];
  assign gs.grad_data  = dp_g;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      acc_q      <= '0;
      ret_q      <= '0;
      rd_pend_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      dp_x_col_q <= '0;
      in_vld_q   <= 1'b0;
      in_idx_q   <= '0;
      vld_q      <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          issue_q <= '0;
          acc_q   <= '0;
          ret_q   <= '0;
        end
        // Leave on the same edge that accepts the last word.
        RUN: if (xfer && acc_q == NC - 1'b1) state_q <= DONE;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      rd_pend_q <= col_rd_en;
      if (col_rd_en) issue_q <= issue_q + 1'b1;
      if (xfer) acc_q <= acc_q + 1'b1;

      if (dp_enable) begin
        // A parked column is older than anything returning now.
        if (skid_vld_q) begin
          dp_x_col_q <= skid_q;
          skid_vld_q <= 1'b0;
          in_vld_q   <= 1'b1;
          in_idx_q   <= ret_q;
          ret_q      <= ret_q + 1'b1;
        end else if (rd_pend_q) begin
          dp_x_col_q <= x_col_in;
          in_vld_q   <= 1'b1;
          in_idx_q   <= ret_q;
          ret_q      <= ret_q + 1'b1;
        end else begin
          in_vld_q   <= 1'b0;
        end
        vld_q[0] <= in_vld_q;
        idx_q[0] <= in_idx_q;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end else if (rd_pend_q) begin
        // Memory data only lasts one cycle; park it while stalled.
        skid_q     <= x_col_in;
        skid_vld_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mbgd_grad_sched.sv
// Bench for mbgd_grad_sched: column memory and datapath stubs, a column-order
// gradient model, per-cycle stream checks and directed timing expectations.
module tb_mbgd_grad_sched;
  localparam int DW  = 8;
  localparam int N   = 8;
  localparam int NC  = 8;
  localparam int CB  = 3;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A: default parameters
  logic            resetn = 1'b1;
  logic            start  = 1'b0;
  logic            busy, done, col_rd_en, dp_enable;
  logic [CB-1:0]   col_addr;
  logic [DW*N-1:0] x_col_in = '0;
  logic [DW*N-1:0] dp_x_col;
  logic [2*DW-1:0] dp_g;

  mbgd_grad_sched_if #(.DW(DW), .COL_BIT(CB)) gs ();

  mbgd_grad_sched #(
    .DW(DW), .N(N), .NUM_COLS(NC), .COL_BIT(CB), .LAT(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .busy(busy), .done(done),
    .col_rd_en(col_rd_en), .col_addr(col_addr), .x_col_in(x_col_in),
    .dp_enable(dp_enable), .dp_x_col(dp_x_col), .dp_g(dp_g),
    .gs(gs)
  );

  // ---------------- DUT B: NUM_COLS=1, LAT=1
  logic            resetn_b = 1'b1;
  logic            start_b  = 1'b0;
  logic            busy_b, done_b, col_rd_en_b, dp_enable_b;
  logic [0:0]      col_addr_b;
  logic [DW*N-1:0] x_col_in_b = '0;
  logic [DW*N-1:0] dp_x_col_b;
  logic [2*DW-1:0] dp_g_b = '0;

  mbgd_grad_sched_if #(.DW(DW), .COL_BIT(1)) gs_b ();

  mbgd_grad_sched #(
    .DW(DW), .N(N), .NUM_COLS(1), .COL_BIT(1), .LAT(1)
  ) dut_b (
    .clk(clk), .resetn(resetn_b), .start(start_b),
    .busy(busy_b), .done(done_b),
    .col_rd_en(col_rd_en_b), .col_addr(col_addr_b), .x_col_in(x_col_in_b),
    .dp_enable(dp_enable_b), .dp_x_col(dp_x_col_b), .dp_g(dp_g_b),
    .gs(gs_b)
  );

  // ---------------- environment stubs
  function automatic logic [DW*N-1:0] col_val(input int k);
    logic [DW*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(k + 1);
    return v;
  endfunction

  // datapath: weighted element sum with weights 1..N
  function automatic logic [15:0] dot(input logic [DW*N-1:0] x);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + 16'(x[i*DW +: DW]) * 16'(i + 1);
    return s;
  endfunction

  // model: column k is all (k+1), so its gradient is (k+1)*N*(N+1)/2
  function automatic int exp_g(input int k);
    return (k + 1) * N * (N + 1) / 2;
  endfunction

  logic [15:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  assign dp_g = pipe[LAT-1];

  always @(posedge clk) begin
    if (col_rd_en) x_col_in <= col_val(int'(col_addr));
    if (dp_enable) begin
      pipe[0] <= dot(dp_x_col);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    if (col_rd_en_b) x_col_in_b <= col_val(int'(col_addr_b));
    if (dp_enable_b) dp_g_b <= dot(dp_x_col_b);
  end

  // ---------------- checking
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int          rd_n, exp_k, xfer_n, done_n, done_cyc;
  int          busy_n, busy_first, busy_last;
  int          rd_cyc [16];
  int          rd_adr [16];
  int          gr_cyc [NC];
  int          gr_dat [NC];
  bit          prev_stall;
  logic [CB-1:0] prev_addr;
  logic [15:0] prev_data;

  task automatic reset_model;
    rd_n = 0; exp_k = 0; xfer_n = 0; done_n = 0; done_cyc = -1;
    busy_n = 0; busy_first = -1; busy_last = -1; prev_stall = 0;
    for (int i = 0; i < NC; i++) begin
      gr_cyc[i] = -1;
      gr_dat[i] = -1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(col_rd_en), 0);
    chk({tag, "_dp_en"}, int'(dp_enable), 0);
    chk({tag, "_gvalid"}, int'(gs.grad_valid), 0);
    chk({tag, "_col_addr"}, int'(col_addr), 0);
    chk({tag, "_gaddr"}, int'(gs.grad_addr), 0);
    chk({tag, "_dpx_zero"}, int'(dp_x_col == '0), 1);
  endtask

  // per-cycle observation of DUT A in pass cycle c
  task automatic sample(input int c);
    if (col_rd_en && rd_n < 16) begin
      rd_cyc[rd_n] = c;
      rd_adr[rd_n] = int'(col_addr);
      rd_n++;
    end
    if (busy) begin
      if (busy_n == 0) busy_first = c;
      busy_last = c;
      busy_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = c;
    end
    if (prev_stall) begin
      chk("hold_valid", int'(gs.grad_valid), 1);
      chk("hold_addr", int'(gs.grad_addr), int'(prev_addr));
      chk("hold_data", int'(gs.grad_data), int'(prev_data));
    end
    if (gs.grad_valid && !gs.grad_ready) begin
      chk("stall_dp_en", int'(dp_enable), 0);
      chk("stall_rd_en", int'(col_rd_en), 0);
    end
    if (gs.grad_valid && gs.grad_ready) begin
      chk("order_addr", int'(gs.grad_addr), exp_k % NC);
      chk("grad_data", int'(gs.grad_data), exp_g(exp_k % NC));
      if (exp_k < NC) begin
        gr_cyc[exp_k] = c;
        gr_dat[exp_k] = int'(gs.grad_data);
      end
      exp_k++;
      xfer_n++;
    end
    prev_stall = gs.grad_valid & ~gs.grad_ready;
    prev_addr  = gs.grad_addr;
    prev_data  = gs.grad_data;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 2) return !(c >= 7 && c <= 10);
    if (mode == 3) return logic'(c % 2 == 1);
    return 1'b1;
  endfunction

  // mode 1 plain, 2 stall window, 3 toggling ready, 4 extra start, 5 mid-pass reset
  task automatic run_pass(input int mode);
    bit fin;
    fin = 0;
    reset_model();
    @(negedge clk);
    start = 1'b1;
    gs.grad_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 80 && !fin; c++) begin
      gs.grad_ready = ready_for(mode, c);
      start  = logic'(mode == 4 && c == 4);
      resetn = logic'(mode == 5 && c == 8);
      @(negedge clk);
      if (mode == 5 && c == 9) begin
        chk_zero("midreset");
        fin = 1;
      end else begin
        sample(c);
        if (done) fin = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!fin) chk("pass_timeout", 0, 1);
    start = 1'b0;
    resetn = 1'b0;
    gs.grad_ready = 1'b1;
  endtask

  task automatic chk_nominal(input string tag);
    chk({tag, "_rd_count"}, rd_n, NC);
    for (int k = 0; k < NC; k++) begin
      chk({tag, "_rd_cycle"}, rd_cyc[k], 1 + k);
      chk({tag, "_rd_addr"}, rd_adr[k], k);
      chk({tag, "_grad_cycle"}, gr_cyc[k], 6 + k);
    end
    chk({tag, "_xfers"}, xfer_n, NC);
    chk({tag, "_done_cycle"}, done_cyc, 14);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_busy_count"}, busy_n, 13);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_busy_last"}, busy_last, 13);
    chk({tag, "_g0_literal"}, gr_dat[0], 36);
    chk({tag, "_g7_literal"}, gr_dat[7], 288);
  endtask

  initial begin
    gs.grad_ready   = 1'b1;
    gs_b.grad_ready = 1'b1;
    resetn   = 1'b1;
    resetn_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn   = 1'b0;
    resetn_b = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // 1: nominal pass
    run_pass(1);
    chk_nominal("t1");

    // 2: backpressure window in cycles 7..10
    run_pass(2);
    chk("t2_xfers", xfer_n, NC);
    chk("t2_done_count", done_n, 1);
    chk("t2_done_cycle", done_cyc, 18);
    chk("t2_g0_cycle", gr_cyc[0], 6);
    chk("t2_g1_cycle", gr_cyc[1], 11);
    chk("t2_g7_cycle", gr_cyc[7], 17);
    chk("t2_rd_count", rd_n, NC);
    chk("t2_rd5_cycle", rd_cyc[5], 6);
    chk("t2_rd6_cycle", rd_cyc[6], 11);
    chk("t2_rd7_cycle", rd_cyc[7], 12);

    // 3: ready toggling every cycle
    run_pass(3);
    chk("t3_xfers", xfer_n, NC);
    chk("t3_order_end", exp_k, NC);
    chk("t3_done_count", done_n, 1);

    // 4: start re-pulsed while busy
    run_pass(4);
    chk("t4_xfers", xfer_n, NC);
    chk("t4_done_count", done_n, 1);
    chk("t4_done_cycle", done_cyc, 14);

    // 5: reset in cycle 8, then a clean pass
    run_pass(5);
    run_pass(1);
    chk_nominal("t5");

    // 6: single column, single-stage datapath
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t6_rd_en", int'(col_rd_en_b), int'(c == 1));
      chk("t6_gvalid", int'(gs_b.grad_valid), int'(c == 4));
      chk("t6_done", int'(done_b), int'(c == 5));
      if (c == 4) begin
        chk("t6_gaddr", int'(gs_b.grad_addr), 0);
        chk("t6_gdata", int'(gs_b.grad_data), 36);
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
